// File: rtl/rrv64_fetch_realign.sv
// Fetch realignment buffer: turns 4-byte fetch words into a stream of 16-bit (RVC)
// and 32-bit instructions, including 32-bit instructions straddling two fetch words.
// A small halfword queue sits between fetch and decode. A fault parks the block in a
// hold state until the next flush.
module rrv64_fetch_realign (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_vld,
  output logic        fetch_rdy,
  input  logic [38:0] fetch_pc,
  input  logic [31:0] fetch_data,
  input  logic        fetch_excp,
  output logic        inst_vld,
  input  logic        inst_rdy,
  output logic [31:0] inst,
  output logic [38:0] inst_pc,
  output logic        inst_is_rvc,
  output logic        inst_excp
);

  typedef enum logic {StRun, StFaultHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] q_data_q [3];
  logic [15:0] q_data_d [3];
  logic [2:0]  q_excp_q, q_excp_d;
  logic [1:0]  count_q, count_d;
  logic [38:0] head_pc_q, head_pc_d;

  logic        run;
  logic        hw0_rvc;
  logic        emit16;
  logic        pop_fire;
  logic        push_fire;
  logic [1:0]  pop_n;
  logic [1:0]  push_n;
  logic [1:0]  remain;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a faulting instruction handed to decode parks us until a flush
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (!flush && pop_fire && inst_excp) state_d = StFaultHold;
      end
      StFaultHold: begin
        if (flush) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs: decode of the queue head and the fetch/decode handshakes
  always_comb begin
    run     = (state_q == StRun);
    hw0_rvc = (q_data_q[0][1:0] != 2'b11);
    // A lone faulting halfword cannot wait for its upper half; emit it 16 bits wide
    emit16  = hw0_rvc || (q_excp_q[0] && (count_q == 2'd1));

    inst_vld = run && !flush &&
               (((count_q >= 2'd1) && (hw0_rvc || q_excp_q[0])) || (count_q >= 2'd2));

    inst_excp   = q_excp_q[0] || (!emit16 && q_excp_q[1]);
    inst_is_rvc = emit16;
    inst_pc     = head_pc_q;
    if (inst_excp) begin
      inst = 32'd0;
    end else if (emit16) begin
      inst = {16'd0, q_data_q[0]};
    end else begin
      inst = {q_data_q[1], q_data_q[0]};
    end

    pop_fire = inst_vld && inst_rdy;
    pop_n    = pop_fire ? (emit16 ? 2'd1 : 2'd2) : 2'd0;
    remain   = count_q - pop_n;
    // Room for a full 2-halfword packet once this cycle's pop is accounted for
    fetch_rdy = run && !flush && (remain <= 2'd1);
    push_fire = fetch_vld && fetch_rdy;
    push_n    = fetch_pc[1] ? 2'd1 : 2'd2;
  end

  // Queue next state: shift out popped entries, then append behind the survivors
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      q_data_d[i] = q_data_q[i];
      q_excp_d[i] = q_excp_q[i];
    end
    count_d   = count_q;
    head_pc_d = head_pc_q;

    if (flush) begin
      count_d = 2'd0;
    end else if (run) begin
      if (pop_n == 2'd1) begin
        q_data_d[0] = q_data_q[1];
        q_excp_d[0] = q_excp_q[1];
        q_data_d[1] = q_data_q[2];
        q_excp_d[1] = q_excp_q[2];
      end else if (pop_n == 2'd2) begin
        q_data_d[0] = q_data_q[2];
        q_excp_d[0] = q_excp_q[2];
      end
      head_pc_d = head_pc_q + {36'd0, pop_n, 1'b0};
      count_d   = remain;

      if (push_fire) begin
        count_d = remain + push_n;
        if (remain == 2'd0) begin
          // Empty after the pop: the packet defines the new head address
          head_pc_d = fetch_pc;
          if (fetch_pc[1]) begin
            q_data_d[0] = fetch_data[31:16];
            q_excp_d[0] = fetch_excp;
          end else begin
            q_data_d[0] = fetch_data[15:0];
            q_excp_d[0] = fetch_excp;
            q_data_d[1] = fetch_data[31:16];
            q_excp_d[1] = fetch_excp;
          end
        end else begin
          if (fetch_pc[1]) begin
            q_data_d[1] = fetch_data[31:16];
            q_excp_d[1] = fetch_excp;
          end else begin
            q_data_d[1] = fetch_data[15:0];
            q_excp_d[1] = fetch_excp;
            q_data_d[2] = fetch_data[31:16];
            q_excp_d[2] = fetch_excp;
          end
        end
      end
    end
  end

  // Queue, count and head address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        q_data_q[i] <= 16'd0;
      end
      q_excp_q  <= 3'd0;
      count_q   <= 2'd0;
      head_pc_q <= 39'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        q_data_q[i] <= q_data_d[i];
      end
      q_excp_q  <= q_excp_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
    end
  end

endmodule

// File: tb/tb_rrv64_fetch_realign.sv
// Bench for rrv64_fetch_realign: directed vector table, a mid-stream reset sequence,
// and a randomized run checked against a halfword-queue reference model.
module tb_rrv64_fetch_realign;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [38:0] fetch_pc;
  logic [31:0] fetch_data;
  logic        fetch_excp;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [38:0] inst_pc;
  logic        inst_is_rvc;
  logic        inst_excp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rrv64_fetch_realign dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_vld   (fetch_vld),
    .fetch_rdy   (fetch_rdy),
    .fetch_pc    (fetch_pc),
    .fetch_data  (fetch_data),
    .fetch_excp  (fetch_excp),
    .inst_vld    (inst_vld),
    .inst_rdy    (inst_rdy),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_is_rvc (inst_is_rvc),
    .inst_excp   (inst_excp)
  );

  typedef struct {
    logic        fl;
    logic        fv;
    logic [38:0] pc;
    logic [31:0] d;
    logic        ex;
    logic        ir;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [38:0] e_pc;
    logic        e_rvc;
    logic        e_exc;
  } vec_t;

  typedef struct {
    logic [15:0] hw;
    logic        ex;
    logic [38:0] pc;
  } hw_t;

  vec_t vq[$];
  hw_t  mq[$];
  logic m_hold;

  function automatic vec_t v(input logic fl, input logic fv, input logic [38:0] pc,
                             input logic [31:0] d, input logic ex, input logic ir,
                             input logic rdy, input logic vld, input logic [31:0] ei,
                             input logic [38:0] ep, input logic er, input logic ee);
    vec_t r;
    r.fl = fl; r.fv = fv; r.pc = pc; r.d = d; r.ex = ex; r.ir = ir;
    r.e_rdy = rdy; r.e_vld = vld; r.e_inst = ei; r.e_pc = ep; r.e_rvc = er; r.e_exc = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [38:0] pc,
                       input logic [31:0] d, input logic ex, input logic ir);
    flush = fl; fetch_vld = fv; fetch_pc = pc; fetch_data = d; fetch_excp = ex;
    inst_rdy = ir;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 39'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("vld_in_reset", 64'(inst_vld), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_hold = 1'b0;
  endtask

  initial begin
    logic [38:0] npc;
    logic        evld, erdy, eexc, ervc, rvc0, ex0, w16;
    logic [31:0] einst;
    logic [38:0] epc;
    int          sz, pop;

    do_reset();

    // Directed table: one record per cycle, checked at the falling edge
    vq.push_back(v(0, 1, 39'h1000, 32'h00130513, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h1004, 32'h00000013, 0, 1, 1, 1, 32'h00130513, 39'h1000, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00000013, 39'h1004, 0, 0));
    vq.push_back(v(0, 1, 39'h2000, 32'h45014581, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 0, 0, 1, 32'h00004581, 39'h2000, 1, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00004581, 39'h2000, 1, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00004501, 39'h2002, 1, 0));
    vq.push_back(v(0, 1, 39'h3000, 32'h05134501, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h3004, 32'h00000013, 0, 1, 1, 1, 32'h00004501, 39'h3000, 1, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00130513, 39'h3002, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 0, 1, 1, 32'h00000000, 39'h3006, 1, 0));
    vq.push_back(v(1, 0, 39'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h4002, 32'h4581abcd, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00004581, 39'h4002, 1, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h5002, 32'h05130000, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h5004, 32'h00000013, 1, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00000000, 39'h5002, 0, 1));
    vq.push_back(v(0, 1, 39'h5008, 32'h12345678, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 39'h5008, 32'h12345678, 0, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 39'h6000, 32'h00130513, 0, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 1, 32'h00130513, 39'h6000, 0, 0));
    vq.push_back(v(0, 1, 39'h7000, 32'h45014581, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 39'h7004, 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 39'h0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].fv, vq[i].pc, vq[i].d, vq[i].ex, vq[i].ir);
      @(negedge clk);
      chk($sformatf("vec%0d_fetch_rdy", i), 64'(fetch_rdy), 64'(vq[i].e_rdy));
      chk($sformatf("vec%0d_inst_vld", i), 64'(inst_vld), 64'(vq[i].e_vld));
      if (vq[i].e_vld) begin
        chk($sformatf("vec%0d_inst", i), 64'(inst), 64'(vq[i].e_inst));
        chk($sformatf("vec%0d_inst_pc", i), 64'(inst_pc), 64'(vq[i].e_pc));
        chk($sformatf("vec%0d_is_rvc", i), 64'(inst_is_rvc), 64'(vq[i].e_rvc));
        chk($sformatf("vec%0d_excp", i), 64'(inst_excp), 64'(vq[i].e_exc));
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted while an instruction is pending
    drive(1'b0, 1'b1, 39'h8000, 32'h00130513, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 39'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pending_before_rst", 64'(inst_vld), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_inst_vld", 64'(inst_vld), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inst_vld", 64'(inst_vld), 64'd0);
    chk("post_rst_fetch_rdy", 64'(fetch_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Randomized run against the halfword-queue model
    do_reset();
    npc = 39'({$urandom, $urandom});
    npc[0] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic fl, fv, ex, ir;
      logic [31:0] d;
      fl = ($urandom_range(0, 15) == 0);
      fv = ($urandom_range(0, 9) < 7);
      ex = ($urandom_range(0, 19) == 0);
      ir = ($urandom_range(0, 9) < 6);
      d  = $urandom;
      drive(fl, fv, npc, d, ex, ir);
      @(negedge clk);

      sz = mq.size();
      evld = 1'b0; erdy = 1'b0; eexc = 1'b0; ervc = 1'b0; einst = 32'd0; epc = 39'd0;
      pop = 0;
      if (!m_hold && !fl) begin
        rvc0 = (sz > 0) && (mq[0].hw[1:0] != 2'b11);
        ex0  = (sz > 0) && mq[0].ex;
        w16  = rvc0 || (ex0 && sz == 1);
        evld = (sz >= 1 && (rvc0 || ex0)) || sz >= 2;
        if (evld) begin
          eexc  = ex0 || (!w16 && mq[1].ex);
          ervc  = w16;
          epc   = mq[0].pc;
          einst = eexc ? 32'd0 : (w16 ? {16'd0, mq[0].hw} : {mq[1].hw, mq[0].hw});
          if (ir) pop = w16 ? 1 : 2;
        end
        erdy = (sz - pop) <= 1;
      end

      chk("rnd_fetch_rdy", 64'(fetch_rdy), 64'(erdy));
      chk("rnd_inst_vld", 64'(inst_vld), 64'(evld));
      if (evld) begin
        chk("rnd_inst", 64'(inst), 64'(einst));
        chk("rnd_inst_pc", 64'(inst_pc), 64'(epc));
        chk("rnd_is_rvc", 64'(inst_is_rvc), 64'(ervc));
        chk("rnd_excp", 64'(inst_excp), 64'(eexc));
      end

      if (fl) begin
        mq.delete();
        m_hold = 1'b0;
        npc = 39'({$urandom, $urandom});
        npc[0] = 1'b0;
      end else if (!m_hold) begin
        repeat (pop) void'(mq.pop_front());
        if (evld && ir && eexc) m_hold = 1'b1;
        if (fv && erdy) begin
          if (!npc[1]) mq.push_back('{hw: d[15:0], ex: ex, pc: npc});
          mq.push_back('{hw: d[31:16], ex: ex, pc: {npc[38:2], 2'b10}});
          npc = {npc[38:2] + 37'd1, 2'b00};
        end
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
